// File: rtl/axis_bram_line_adapter.sv
// Packs AXI-Stream words into wide BRAM lines (write) or unpacks lines onto a stream (read).
// Optional macro PARTIAL_FLUSH_EN: s_axis_tlast in write mode commits a zero-padded line and ends the command.
module axis_bram_line_adapter #(
  parameter int WORD_W         = 32,
  parameter int WORDS_PER_LINE = 4,
  parameter int ADDR_W         = 9
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               start,
  input  logic                               rw,
  input  logic [ADDR_W-1:0]                  base_addr,
  input  logic [ADDR_W-1:0]                  num_lines,
  output logic                               busy,
  output logic                               done,
  input  logic [WORD_W-1:0]                  s_axis_tdata,
  input  logic                               s_axis_tvalid,
  input  logic                               s_axis_tlast,
  output logic                               s_axis_tready,
  output logic [WORD_W-1:0]                  m_axis_tdata,
  output logic                               m_axis_tvalid,
  output logic                               m_axis_tlast,
  input  logic                               m_axis_tready,
  output logic                               bram_en,
  output logic                               bram_we,
  output logic [ADDR_W-1:0]                  bram_addr,
  output logic [WORD_W*WORDS_PER_LINE-1:0]   bram_din,
  input  logic [WORD_W*WORDS_PER_LINE-1:0]   bram_dout
);

  localparam int CNT_W  = $clog2(WORDS_PER_LINE);
  localparam int LINE_W = WORD_W * WORDS_PER_LINE;
  localparam logic [CNT_W-1:0]  LAST_SLOT = CNT_W'(WORDS_PER_LINE - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
  localparam logic [ADDR_W:0]   LINE_ONE  = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);

  typedef enum logic [2:0] {
    IDLE, WR_FILL, WR_COMMIT, RD_REQ, RD_WAIT, RD_SEND, FIN
  } state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [ADDR_W:0]    line;
  logic [ADDR_W-1:0]  base_q;
  logic [ADDR_W-1:0]  num_q;
  logic [LINE_W-1:0]  line_buf;
  logic [LINE_W-1:0]  fill_line;
  logic               flush_q;
  logic               flush_hit;
  logic               last_line;
  logic [CNT_W-1:0]   cnt_nxt;
  logic [ADDR_W-1:0]  next_addr;

  assign cnt_nxt   = cnt + CNT_ONE;
  assign last_line = (line + LINE_ONE) == {1'b0, num_q};
  assign next_addr = base_q + line[ADDR_W-1:0] + ADDR_ONE;

`ifdef PARTIAL_FLUSH_EN
  assign flush_hit = s_axis_tlast;
`else
  logic unused_tlast;
  assign unused_tlast = s_axis_tlast;
  assign flush_hit    = 1'b0;
`endif

  // Line as it will look after storing the current stream word; a flush zeroes the slots above it.
  always_comb begin
    fill_line = line_buf;
    for (int i = 0; i < WORDS_PER_LINE; i++) begin
      if (i == int'(cnt))
        fill_line[i*WORD_W +: WORD_W] = s_axis_tdata;
      else if (flush_hit && i > int'(cnt))
        fill_line[i*WORD_W +: WORD_W] = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      cnt           <= '0;
      line          <= '0;
      base_q        <= '0;
      num_q         <= '0;
      line_buf      <= '0;
      flush_q       <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      s_axis_tready <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      bram_en       <= 1'b0;
      bram_we       <= 1'b0;
      bram_addr     <= '0;
      bram_din      <= '0;
    end else begin
      case (state)
        IDLE: begin
          done    <= 1'b0;
          cnt     <= '0;
          line    <= '0;
          flush_q <= 1'b0;
          if (start) begin
            base_q <= base_addr;
            num_q  <= num_lines;
            if (num_lines == '0) begin
              state <= FIN;
            end else if (rw) begin
              state         <= WR_FILL;
              busy          <= 1'b1;
              s_axis_tready <= 1'b1;
            end else begin
              state     <= RD_REQ;
              busy      <= 1'b1;
              bram_en   <= 1'b1;
              bram_we   <= 1'b0;
              bram_addr <= base_addr;
            end
          end
        end

        WR_FILL: begin
          if (s_axis_tvalid) begin
            line_buf <= fill_line;
            cnt      <= cnt_nxt;
            if (cnt == LAST_SLOT || flush_hit) begin
              state         <= WR_COMMIT;
              s_axis_tready <= 1'b0;
              bram_en       <= 1'b1;
              bram_we       <= 1'b1;
              bram_addr     <= base_q + line[ADDR_W-1:0];
              bram_din      <= fill_line;
              flush_q       <= flush_hit;
            end
          end
        end

        WR_COMMIT: begin
          bram_en <= 1'b0;
          bram_we <= 1'b0;
          cnt     <= '0;
          line    <= line + LINE_ONE;
          if (last_line || flush_q) begin
            state <= FIN;
            busy  <= 1'b0;
          end else begin
            state         <= WR_FILL;
            s_axis_tready <= 1'b1;
          end
        end

        RD_REQ: begin
          bram_en <= 1'b0;
          state   <= RD_WAIT;
        end

        // The read line arrives one cycle after the request and is parked in the line buffer.
        RD_WAIT: begin
          line_buf      <= bram_dout;
          cnt           <= '0;
          m_axis_tvalid <= 1'b1;
          m_axis_tdata  <= bram_dout[WORD_W-1:0];
          m_axis_tlast  <= 1'b0;
          state         <= RD_SEND;
        end

        RD_SEND: begin
          if (m_axis_tready) begin
            if (cnt == LAST_SLOT) begin
              m_axis_tvalid <= 1'b0;
              m_axis_tdata  <= '0;
              m_axis_tlast  <= 1'b0;
              cnt           <= '0;
              line          <= line + LINE_ONE;
              if (last_line) begin
                state <= FIN;
                busy  <= 1'b0;
              end else begin
                state     <= RD_REQ;
                bram_en   <= 1'b1;
                bram_addr <= next_addr;
              end
            end else begin
              cnt          <= cnt_nxt;
              m_axis_tdata <= line_buf[cnt_nxt*WORD_W +: WORD_W];
              m_axis_tlast <= (cnt_nxt == LAST_SLOT) && last_line;
            end
          end
        end

        FIN: begin
          done  <= 1'b1;
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axis_bram_line_adapter.sv
// Directed bench for axis_bram_line_adapter with a behavioural BRAM; optional PARTIAL_FLUSH_EN case.
module tb_axis_bram_line_adapter;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         rw = 1'b0;
  logic [8:0]   base_addr = '0;
  logic [8:0]   num_lines = '0;
  logic         busy, done;
  logic [31:0]  s_axis_tdata = '0;
  logic         s_axis_tvalid = 1'b0;
  logic         s_axis_tlast = 1'b0;
  logic         s_axis_tready;
  logic [31:0]  m_axis_tdata;
  logic         m_axis_tvalid, m_axis_tlast;
  logic         m_axis_tready = 1'b0;
  logic         bram_en, bram_we;
  logic [8:0]   bram_addr;
  logic [127:0] bram_din;
  logic [127:0] bram_dout = '0;

  logic [127:0] mem [0:511];
  logic [8:0]   addr_log [$];
  int           n_checks = 0;
  int           n_fail = 0;
  int           done_count = 0;
  int           en_count = 0;
  int           s_hs_count = 0;
  int           m_hs_count = 0;

  axis_bram_line_adapter dut (
    .clk(clk), .rst(rst), .start(start), .rw(rw),
    .base_addr(base_addr), .num_lines(num_lines),
    .busy(busy), .done(done),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tlast(s_axis_tlast), .s_axis_tready(s_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tlast(m_axis_tlast), .m_axis_tready(m_axis_tready),
    .bram_en(bram_en), .bram_we(bram_we), .bram_addr(bram_addr),
    .bram_din(bram_din), .bram_dout(bram_dout)
  );

  always #5 clk = ~clk;

  // Behavioural single-port BRAM plus activity monitors.
  always @(posedge clk) begin
    if (bram_en) begin
      en_count <= en_count + 1;
      addr_log.push_back(bram_addr);
      if (bram_we) mem[bram_addr] <= bram_din;
      else         bram_dout      <= mem[bram_addr];
    end
    if (done) done_count <= done_count + 1;
    if (s_axis_tvalid && s_axis_tready) s_hs_count <= s_hs_count + 1;
    if (m_axis_tvalid && m_axis_tready) m_hs_count <= m_hs_count + 1;
  end

  task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
    n_checks++;
    assert (observed === expected) else begin
      n_fail++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic cmd_rw, input logic [8:0] base, input logic [8:0] lines);
    @(posedge clk); #1;
    start = 1'b1; rw = cmd_rw; base_addr = base; num_lines = lines;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic sendWord(input logic [31:0] data, input logic last);
    int k = 0;
    s_axis_tdata = data; s_axis_tlast = last; s_axis_tvalid = 1'b1;
    do begin @(negedge clk); k++; end while (!s_axis_tready && k < 50);
    checkOutput("s_tready", s_axis_tready, 1);
    @(posedge clk); #1;
    s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
  endtask

  task automatic rxWord(input logic [31:0] exp_data, input logic exp_last, input logic stall);
    int k = 0;
    m_axis_tready = 1'b0;
    do begin @(negedge clk); k++; end while (!m_axis_tvalid && k < 50);
    checkOutput("m_tvalid", m_axis_tvalid, 1);
    checkOutput("m_tdata", m_axis_tdata, exp_data);
    if (stall) begin
      @(posedge clk); @(negedge clk);
      checkOutput("m_tdata_held", m_axis_tdata, exp_data);
      checkOutput("m_tvalid_held", m_axis_tvalid, 1);
    end
    checkOutput("m_tlast", m_axis_tlast, exp_last);
    m_axis_tready = 1'b1;
    @(posedge clk); #1;
    m_axis_tready = 1'b0;
  endtask

  task automatic waitDone(input string tag, input int target);
    int k = 0;
    while (done_count < target && k < 200) begin @(negedge clk); k++; end
    repeat (3) @(negedge clk);
    checkOutput(tag, done_count, target);
    checkOutput({tag, "_busy"}, busy, 0);
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_busy"}, busy, 0);
    checkOutput({tag, "_done"}, done, 0);
    checkOutput({tag, "_s_tready"}, s_axis_tready, 0);
    checkOutput({tag, "_m_tvalid"}, m_axis_tvalid, 0);
    checkOutput({tag, "_m_tlast"}, m_axis_tlast, 0);
    checkOutput({tag, "_m_tdata"}, m_axis_tdata, 0);
    checkOutput({tag, "_bram_en"}, bram_en, 0);
    checkOutput({tag, "_bram_we"}, bram_we, 0);
    checkOutput({tag, "_bram_addr"}, bram_addr, 0);
    checkOutput({tag, "_bram_din"}, bram_din, 0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int en_before, s_before, m_before;
    for (int i = 0; i < 512; i++) mem[i] = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    checkResetOutputs("reset");
    rst = 1'b0;

    // Write two lines at 0x10
    applyStimulus(1'b1, 9'h010, 9'd2);
    checkOutput("wr_busy", busy, 1);
    for (int w = 1; w <= 8; w++) sendWord(32'(w), 1'b0);
    waitDone("wr_done", 1);
    checkOutput("wr_line0", mem[9'h010], {32'h4, 32'h3, 32'h2, 32'h1});
    checkOutput("wr_line1", mem[9'h011], {32'h8, 32'h7, 32'h6, 32'h5});
    checkOutput("wr_m_tvalid_idle", m_axis_tvalid, 0);
    checkOutput("wr_m_tdata_idle", m_axis_tdata, 0);

    // Read the same lines back with a stall before every word
    applyStimulus(1'b0, 9'h010, 9'd2);
    for (int w = 1; w <= 8; w++) rxWord(32'(w), w == 8, 1'b1);
    waitDone("rd_done", 2);
    checkOutput("rd_m_tvalid_idle", m_axis_tvalid, 0);
    checkOutput("rd_m_tdata_idle", m_axis_tdata, 0);

    // Address wrap, with a stray start while busy
    addr_log.delete();
    applyStimulus(1'b1, 9'h1FF, 9'd2);
    sendWord(32'h11, 1'b0);
    start = 1'b1; rw = 1'b0; base_addr = 9'h000; num_lines = 9'd0;
    @(posedge clk); #1;
    start = 1'b0;
    for (int w = 2; w <= 8; w++) sendWord(32'h10 + 32'(w), 1'b0);
    waitDone("wrap_done", 3);
    checkOutput("wrap_n_access", addr_log.size(), 2);
    checkOutput("wrap_addr0", addr_log[0], 9'h1FF);
    checkOutput("wrap_addr1", addr_log[1], 9'h000);
    checkOutput("wrap_line0", mem[9'h1FF], {32'h14, 32'h13, 32'h12, 32'h11});
    checkOutput("wrap_line1", mem[9'h000], {32'h18, 32'h17, 32'h16, 32'h15});

    // Zero-line command
    en_before = en_count; s_before = s_hs_count; m_before = m_hs_count;
    applyStimulus(1'b1, 9'h020, 9'd0);
    checkOutput("zero_done_early", done, 0);
    checkOutput("zero_busy", busy, 0);
    @(posedge clk); #1;
    checkOutput("zero_done", done, 1);
    @(posedge clk); #1;
    checkOutput("zero_done_pulse", done, 0);
    checkOutput("zero_no_bram", en_count, en_before);
    checkOutput("zero_no_s_hs", s_hs_count, s_before);
    checkOutput("zero_no_m_hs", m_hs_count, m_before);

    // Reset in the middle of a read
    applyStimulus(1'b0, 9'h010, 9'd2);
    rxWord(32'h1, 1'b0, 1'b0);
    rxWord(32'h2, 1'b0, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    checkResetOutputs("midrst");
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("midrst_no_done", done_count, 4);
    applyStimulus(1'b0, 9'h011, 9'd1);
    for (int w = 5; w <= 8; w++) rxWord(32'(w), w == 8, 1'b0);
    waitDone("postrst_done", 5);

`ifdef PARTIAL_FLUSH_EN
    // tlast on word 6 flushes a padded line and ends the command early
    applyStimulus(1'b1, 9'h050, 9'd3);
    for (int w = 1; w <= 6; w++) sendWord(32'(w), w == 6);
    waitDone("flush_done", 6);
    checkOutput("flush_line0", mem[9'h050], {32'h4, 32'h3, 32'h2, 32'h1});
    checkOutput("flush_line1", mem[9'h051], {32'h0, 32'h0, 32'h6, 32'h5});
    checkOutput("flush_line2", mem[9'h052], 128'h0);
`else
    // tlast mid-line has no effect; the full line is still collected
    applyStimulus(1'b1, 9'h040, 9'd1);
    for (int w = 1; w <= 4; w++) sendWord(32'h20 + 32'(w), w == 2);
    waitDone("notlast_done", 6);
    checkOutput("notlast_line", mem[9'h040], {32'h24, 32'h23, 32'h22, 32'h21});
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/axis_bram_line_adapter.md
AXIS_BRAM_LINE_ADAPTER -- requirements
Module: axis_bram_line_adapter

Interface
REQ-001 SHALL have parameter WORD_W, default 32, stream word width in bits.
REQ-002 SHALL have parameter WORDS_PER_LINE, default 4, stream words packed per BRAM line (range 2..64).
REQ-003 SHALL have parameter ADDR_W, default 9, BRAM address width.
REQ-004 SHALL have ports:
  clk  in  1  single clock, all logic on rising edge.
  rst  in  1  synchronous reset, active-high.
  start  in  1  one-cycle command strobe, sampled only in IDLE.
  rw  in  1  1 = stream-to-BRAM (write), 0 = BRAM-to-stream (read); sampled with start.
  base_addr  in  ADDR_W  first line address; sampled with start.
  num_lines  in  ADDR_W  line count; sampled with start.
  busy  out  1  high from the cycle after an accepted start until done.
  done  out  1  one-cycle pulse at command end.
  s_axis_tdata/tvalid/tlast  in  WORD_W/1/1  input stream.
  s_axis_tready  out  1  input stream ready.
  m_axis_tdata  out  WORD_W  output stream data.
  m_axis_tvalid/tlast  out  1/1  output stream valid and last.
  m_axis_tready  in  1  output stream ready.
  bram_en/bram_we  out  1/1  BRAM enable / write enable.
  bram_addr  out  ADDR_W  BRAM line address.
  bram_din  out  WORD_W*WORDS_PER_LINE  BRAM write line.
  bram_dout  in  WORD_W*WORDS_PER_LINE  BRAM read line, valid 1 cycle after bram_en with bram_we=0.

Function
REQ-005 SHALL implement states IDLE, WR_FILL, WR_COMMIT, RD_REQ, RD_WAIT, RD_SEND, FIN.
REQ-006 IDLE: start=1 with num_lines=0 SHALL go to FIN with no BRAM or stream activity; otherwise rw=1 -> WR_FILL, rw=0 -> RD_REQ.
REQ-007 Word i of a line (0-based, stream order) SHALL occupy bits [i*WORD_W +: WORD_W]; word 0 first on both streams.
REQ-008 WR_FILL: s_axis_tready=1; each handshake SHALL store the word in slot cnt and increment cnt; on the handshake with cnt=WORDS_PER_LINE-1 -> WR_COMMIT.
REQ-009 WR_COMMIT: s_axis_tready=0; bram_en=bram_we=1 for exactly one cycle with bram_addr=base_addr+line; then line increments and cnt clears; last line -> FIN, else WR_FILL.
REQ-010 Read path: RD_REQ asserts bram_en=1, bram_we=0 for one cycle; RD_WAIT captures bram_dout into the line buffer; then RD_SEND.
REQ-011 RD_SEND: m_axis_tvalid=1 with m_axis_tdata = slot cnt; cnt advances only on tvalid&&tready; tdata SHALL stay stable while tvalid&&!tready.
REQ-012 m_axis_tlast SHALL be 1 only on word WORDS_PER_LINE-1 of line num_lines-1.
REQ-013 After the final word of a line is accepted: last line -> FIN, else RD_REQ for line+1.
REQ-014 FIN SHALL pulse done for one cycle and return to IDLE; busy=0 in IDLE and FIN.
REQ-015 bram_addr SHALL wrap modulo 2^ADDR_W (base_addr=2^ADDR_W-1, 2 lines -> addresses max, 0).
REQ-016 In write mode, s_axis_tlast is ignored unless PARTIAL_FLUSH_EN is defined; m_axis outputs SHALL be 0 outside RD_SEND.
REQ-017 start while busy SHALL be ignored; parameters latched at start SHALL not change mid-command.
REQ-018 cnt width SHALL be clog2(WORDS_PER_LINE); line counter width ADDR_W+1.

Reset
REQ-019 rst=1 SHALL force IDLE within the same clock edge, abandoning any command, with no done pulse.
REQ-020 Reset values: busy, done, s_axis_tready, m_axis_tvalid, m_axis_tlast, bram_en, bram_we = 0; bram_addr, bram_din, m_axis_tdata = 0; cnt and line = 0.

Configuration
REQ-021 Macro PARTIAL_FLUSH_EN defined: in WR_FILL a handshake with s_axis_tlast=1 SHALL zero unwritten slots, commit that line, then go to FIN regardless of remaining num_lines.
REQ-022 PARTIAL_FLUSH_EN undefined: s_axis_tlast has no effect; the command completes only after num_lines full lines.

Verification
REQ-023 Write, base_addr=0x10, num_lines=2, 8 words 0x1..0x8 -> line 0x10 = {4,3,2,1}, line 0x11 = {8,7,6,5}, one done pulse.
REQ-024 Read, base_addr=0x10, num_lines=2, tready toggling 1/0 -> words 1..8 in order, each held while stalled, tlast only on word 8.
REQ-025 base_addr=0x1FF, num_lines=2 (ADDR_W=9) -> BRAM accesses at 0x1FF then 0x000.
REQ-026 num_lines=0 -> done 2 cycles after start, no bram_en, no stream handshakes.
REQ-027 rst asserted mid-read after word 2 -> next cycle all outputs at reset values, new start then behaves normally.
REQ-028 PARTIAL_FLUSH_EN defined, num_lines=3, 6 words with tlast on word 6 -> lines {4,3,2,1} and {0,0,6,5} written, done, third line never written.
